// File: rtl/hack_memory_pkg.sv
// Shared address map, screen geometry and scanner state type for the Hack data memory.
// The region decoder is shared so every consumer agrees on the map.
package hack_memory_pkg;

  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  localparam int SCREEN_COLS   = 512;
  localparam int SCREEN_ROWS   = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int PIX_PER_WORD  = 16;

  typedef enum logic {
    SCAN_IDLE   = 1'b0,
    SCAN_ACTIVE = 1'b1
  } scan_state_t;

  typedef enum logic [1:0] {
    REGION_RAM    = 2'd0,
    REGION_SCREEN = 2'd1,
    REGION_KBD    = 2'd2,
    REGION_NONE   = 2'd3
  } region_t;

  // The screen window is 8K-aligned, so a top-3-bit match identifies it.
  function automatic region_t decode_region(input logic [15:0] addr);
    region_t r;
    if (addr < SCREEN_BASE) begin
      r = REGION_RAM;
    end else if ((addr & 16'hE000) == SCREEN_BASE) begin
      r = REGION_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REGION_KBD;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_memory_screen_scanner.sv
// Frame scanner: walks the screen buffer word by word and serialises each word
// LSB-first (bit 0 is the leftmost pixel) onto the pixel port.
module screen_scanner
  import hack_memory_pkg::*;
#(
  parameter int SCREEN_WORDS = SCREEN_ROWS * WORDS_PER_ROW,
  localparam int WORD_AW = $clog2(SCREEN_WORDS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_scan_start,
  output logic [WORD_AW-1:0] o_rd_addr,
  input  logic [15:0]        i_rd_data,
  output logic               o_pixel,
  output logic               o_pixel_valid,
  output logic               o_line_start,
  output logic               o_frame_done
);

  localparam int PIX_W = $clog2(SCREEN_WORDS * PIX_PER_WORD);
  localparam int COL_W = $clog2(SCREEN_COLS);
  localparam logic [PIX_W-1:0]   LAST_PIX = '1;
  localparam logic [PIX_W-1:0]   PIX_ONE  = 1;
  localparam logic [WORD_AW-1:0] WORD_ONE = 1;

  scan_state_t      r_state;
  logic [PIX_W-1:0] r_pix;
  logic [15:0]      r_shift;
  logic             r_frame_done;

  logic w_active;
  logic w_last;
  logic w_word_end;

  assign w_active   = (r_state == SCAN_ACTIVE);
  assign w_last     = (r_pix == LAST_PIX);
  assign w_word_end = (r_pix[3:0] == 4'hF);

  // While idle the port points at word 0 so a start can load it directly;
  // while active it points at the word that follows the current one.
  assign o_rd_addr = w_active ? (r_pix[PIX_W-1:4] + WORD_ONE) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= SCAN_IDLE;
      r_pix        <= '0;
      r_shift      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          if (i_scan_start) begin
            r_shift <= i_rd_data;
            r_pix   <= '0;
            r_state <= SCAN_ACTIVE;
          end
        end
        SCAN_ACTIVE: begin
          if (w_last) begin
            r_state      <= SCAN_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_pix <= r_pix + PIX_ONE;
            if (w_word_end) begin
              r_shift <= i_rd_data;
            end else begin
              r_shift <= {1'b0, r_shift[15:1]};
            end
          end
        end
        default: r_state <= SCAN_IDLE;
      endcase
    end
  end

  assign o_pixel       = w_active & r_shift[0];
  assign o_pixel_valid = w_active;
  assign o_line_start  = w_active && (r_pix[COL_W-1:0] == '0);
  assign o_frame_done  = r_frame_done;

endmodule

// File: rtl/hack_memory.sv
// Hack data memory: RAM, screen buffer with a second read port for the scanner,
// keyboard register and combinational CPU read path.
module hack_memory
  import hack_memory_pkg::*;
#(
  // Reduced sizes alias the address window modulo the depth.
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = SCREEN_ROWS * WORDS_PER_ROW
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address_m,
  input  logic [15:0] out_m,
  input  logic        write_m,
  output logic [15:0] in_m,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  input  logic        scan_start,
  output logic        pixel,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_done
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  logic [15:0] r_ram    [RAM_WORDS];
  logic [15:0] r_screen [SCREEN_WORDS];
  logic [15:0] r_kbd;

  region_t           w_region;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;
  logic [SCR_AW-1:0] w_scan_addr;
  logic [15:0]       w_scan_data;

  assign w_region  = decode_region(address_m);
  assign w_ram_idx = address_m[RAM_AW-1:0];
  // Low bits equal address_m - SCREEN_BASE because the window is 8K-aligned.
  assign w_scr_idx = address_m[SCR_AW-1:0];

  always_ff @(posedge clock) begin
    if (write_m && (w_region == REGION_RAM)) begin
      r_ram[w_ram_idx] <= out_m;
    end
  end

  always_ff @(posedge clock) begin
    if (write_m && (w_region == REGION_SCREEN)) begin
      r_screen[w_scr_idx] <= out_m;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_kbd <= 16'h0000;
    end else begin
      r_kbd <= key_valid ? key_code : 16'h0000;
    end
  end

  always_comb begin
    in_m = 16'h0000;
    case (w_region)
      REGION_RAM:    in_m = r_ram[w_ram_idx];
      REGION_SCREEN: in_m = r_screen[w_scr_idx];
      REGION_KBD:    in_m = r_kbd;
      default:       in_m = 16'h0000;
    endcase
  end

  // Scanner port reads the pre-edge contents, so a same-edge CPU write shows next frame.
  assign w_scan_data = r_screen[w_scan_addr];

  screen_scanner #(
    .SCREEN_WORDS(SCREEN_WORDS)
  ) u_scanner (
    .clock        (clock),
    .reset        (reset),
    .i_scan_start (scan_start),
    .o_rd_addr    (w_scan_addr),
    .i_rd_data    (w_scan_data),
    .o_pixel      (pixel),
    .o_pixel_valid(pixel_valid),
    .o_line_start (line_start),
    .o_frame_done (frame_done)
  );

endmodule
